// File: rtl/seq_divider_pkg.sv
// Shared encodings for the multicycle divide/multiply units.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit and seq_divider.
// DIVU_SUPPORT_EN adds the is_unsigned request bit.
interface seq_divider_if #(
  parameter int WIDTH = seq_divider_pkg::DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIVU_SUPPORT_EN
  logic             is_unsigned;

  modport master (
    output start, dividend, divisor, is_unsigned,
    input  busy, done, div_by_zero, quotient, remainder
  );
  modport slave (
    input  start, dividend, divisor, is_unsigned,
    output busy, done, div_by_zero, quotient, remainder
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
`endif

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring shift-compare-subtract step on unsigned magnitudes.
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff_lo;
  logic             fits;

  // The shifted remainder needs one extra bit; the difference always fits in WIDTH.
  assign trial   = {rem_i, quo_i[WIDTH-1]};
  assign fits    = (trial >= {1'b0, divisor_i});
  assign diff_lo = trial[WIDTH-1:0] - divisor_i;

  assign rem_o = fits ? diff_lo : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider (restoring, one quotient bit per clock) for HI/LO.
// DIVU_SUPPORT_EN enables unsigned division through bus.is_unsigned.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             signed_op;
  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic             divisor_zero;
  logic [WIDTH-1:0] step_rem, step_quo;

`ifdef DIVU_SUPPORT_EN
  assign signed_op = ~bus.is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  // Unsigned requests clear both signs, so FIX never negates them.
  assign in_sign_a    = signed_op & bus.dividend[WIDTH-1];
  assign in_sign_b    = signed_op & bus.divisor[WIDTH-1];
  assign in_mag_a     = in_sign_a ? (ZERO_W - bus.dividend) : bus.dividend;
  assign in_mag_b     = in_sign_b ? (ZERO_W - bus.divisor) : bus.divisor;
  assign divisor_zero = (bus.divisor == ZERO_W);

  seq_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = divisor_zero ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (bus.start && divisor_zero) begin
          dbz_d = 1'b1;
        end else if (bus.start) begin
          rem_d    = ZERO_W;
          quo_d    = in_mag_a;
          dvsr_d   = in_mag_b;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          cnt_d    = CNT_INIT;
          dbz_d    = 1'b0;
        end else begin
          dbz_d = dbz_q;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_ONE;
      end
      S_FIX: begin
        // Truncation toward zero: remainder follows the dividend's sign.
        quotient_d  = (sign_a_q ^ sign_b_q) ? (ZERO_W - quo_q) : quo_q;
        remainder_d = sign_a_q ? (ZERO_W - rem_q) : rem_q;
      end
      S_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvsr_q      <= {WIDTH{1'b0}};
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
    end else begin
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands vs. an arithmetic model.
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_divider_if dif ();

  seq_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [31:0] exp_q = 32'd0, exp_r = 32'd0;
  logic [31:0] prev_q = 32'd0, prev_r = 32'd0;
  logic        exp_dbz = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: MIPS DIV via 64-bit signed arithmetic (truncation toward zero).
  task automatic model_op(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    prev_q = exp_q;
    prev_r = exp_r;
    if (b == 32'd0) begin
      exp_dbz = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      exp_q = q[31:0];
      exp_r = r[31:0];
      exp_dbz = 1'b0;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    model_op(a, b);
    @(negedge clk);
    dif.start = 1'b0;
    cyc = 1;
    check_eq("busy_after_accept", {31'd0, dif.busy}, 32'd1);
  endtask

  task automatic finish_op(input int lat);
    while (dif.done !== 1'b1 && cyc < 200) begin
      check_eq("busy_during", {31'd0, dif.busy}, 32'd1);
      check_eq("hold_q", dif.quotient, prev_q);
      check_eq("hold_r", dif.remainder, prev_r);
      check_eq("dbz_during", {31'd0, dif.div_by_zero}, {31'd0, exp_dbz});
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", cyc, lat);
    check_eq("done", {31'd0, dif.done}, 32'd1);
    check_eq("quotient", dif.quotient, exp_q);
    check_eq("remainder", dif.remainder, exp_r);
    check_eq("div_by_zero", {31'd0, dif.div_by_zero}, {31'd0, exp_dbz});
    @(negedge clk);
    check_eq("done_pulse_end", {31'd0, dif.done}, 32'd0);
    check_eq("busy_idle", {31'd0, dif.busy}, 32'd0);
    check_eq("held_q", dif.quotient, exp_q);
    check_eq("held_r", dif.remainder, exp_r);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    launch(a, b);
    finish_op((b == 32'd0) ? 1 : 34);
  endtask

  initial begin
    int seen;
    int sel;
    logic [31:0] a, b;

    reset        = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = 32'd0;
    dif.divisor  = 32'd0;
`ifdef DIVU_SUPPORT_EN
    dif.is_unsigned = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, dif.busy}, 32'd0);
    check_eq("rst_done", {31'd0, dif.done}, 32'd0);
    check_eq("rst_dbz", {31'd0, dif.div_by_zero}, 32'd0);
    check_eq("rst_q", dif.quotient, 32'd0);
    check_eq("rst_r", dif.remainder, 32'd0);
    reset = 1'b0;

    run_op(32'd100, 32'd7);
    check_eq("100/7_q", dif.quotient, 32'd14);
    check_eq("100/7_r", dif.remainder, 32'd2);
    run_op(32'd5, 32'd0);
    check_eq("5/0_q_kept", dif.quotient, 32'd14);
    check_eq("5/0_r_kept", dif.remainder, 32'd2);
    check_eq("5/0_dbz", {31'd0, dif.div_by_zero}, 32'd1);
    run_op(-32'sd100, 32'd7);
    check_eq("-100/7_q", dif.quotient, 32'hFFFF_FFF2);
    check_eq("-100/7_r", dif.remainder, 32'hFFFF_FFFE);
    run_op(32'd100, -32'sd7);
    check_eq("100/-7_q", dif.quotient, 32'hFFFF_FFF2);
    check_eq("100/-7_r", dif.remainder, 32'd2);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("min/-1_q", dif.quotient, 32'h8000_0000);
    check_eq("min/-1_r", dif.remainder, 32'd0);
    check_eq("min/-1_dbz", {31'd0, dif.div_by_zero}, 32'd0);

    // A start while busy must be ignored.
    launch(32'd100, 32'd7);
    repeat (8) begin
      @(negedge clk);
      cyc++;
    end
    dif.start    = 1'b1;
    dif.dividend = 32'd9;
    dif.divisor  = 32'd3;
    @(negedge clk);
    cyc++;
    dif.start = 1'b0;
    finish_op(34);
    check_eq("ignored_start_q", dif.quotient, 32'd14);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(0, 16)) - 32'd8;
        4: a = 32'($urandom_range(0, 40)) - 32'd20;
        5: begin
          a = 32'($urandom_range(0, 1000)) - 32'd500;
          b = 32'($urandom_range(1, 30));
        end
        default: a = a;
      endcase
      run_op(a, b);
    end

    // Reset mid-operation aborts with no done pulse.
    launch(32'd100, 32'd7);
    repeat (19) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    #1;
    check_eq("abort_busy", {31'd0, dif.busy}, 32'd0);
    check_eq("abort_done", {31'd0, dif.done}, 32'd0);
    check_eq("abort_q", dif.quotient, 32'd0);
    check_eq("abort_r", dif.remainder, 32'd0);
    check_eq("abort_dbz", {31'd0, dif.div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q = 32'd0;
    exp_r = 32'd0;
    exp_dbz = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done === 1'b1) seen++;
    end
    check_eq("no_done_after_reset", seen, 0);
    check_eq("idle_after_reset", {31'd0, dif.busy}, 32'd0);

    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9);
    check_eq("-100/-7_q", dif.quotient, 32'd14);
    check_eq("-100/-7_r", dif.remainder, 32'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
